// File: rtl/sll_seq.sv
`timescale 1ns/1ps
// sll_seq: sequential logical-left shifter.
//
// Resolves the shift amount one binary stage per clock: stage k shifts by 2^k
// when the current low bit of the remaining shift amount is set. Both sides use
// valid/ready handshakes; one operand is in flight at a time.
//
// Optional feature macro: SLL_EARLY_EXIT_EN
//   defined   - SHIFT ends after the stage that clears the remaining shift amount
//               (latency = index of highest set shamt bit + 1, minimum 1).
//   undefined - SHIFT always runs $clog2(N) stages (fixed latency).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_valid  in   operand valid
//   i_ready  out  block can accept an operand (IDLE and not in reset)
//   in       in   operand, N bits
//   shamt    in   shift amount, $clog2(N) bits
//   o_valid  out  result valid (DONE)
//   o_ready  in   consumer accepts result
//   out      out  result register, in << shamt
//   busy     out  high in SHIFT or DONE
module sll_seq #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [N-1:0]         out,
    output logic                 busy
);

    localparam int L = $clog2(N);
    localparam logic [L-1:0] LAST_K = L[L-1:0] - 1'b1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   state, state_nxt;
    logic [N-1:0] data, data_nxt;
    logic [L-1:0] sh, sh_nxt;
    logic [L-1:0] k, k_nxt;
    logic         last_stage;

    // Handshake outputs depend on state only (plus reset masking of i_ready).
    assign i_ready = (state == IDLE) && !rst;
    assign o_valid = (state == DONE);
    assign busy    = (state == SHIFT) || (state == DONE);
    assign out     = data;

    always_comb begin
        last_stage = 1'b0;
`ifdef SLL_EARLY_EXIT_EN
        // Stop once no set bits remain after this stage's consumption of sh[0].
        last_stage = ((sh >> 1) == '0);
`else
        last_stage = (k == LAST_K);
`endif
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        sh_nxt    = sh;
        k_nxt     = k;
        case (state)
            IDLE: begin
                if (i_valid && i_ready) begin
                    data_nxt  = in;
                    sh_nxt    = shamt;
                    k_nxt     = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sh[0]) begin
                    data_nxt = data << (32'd1 << k);
                end
                sh_nxt = sh >> 1;
                k_nxt  = k + 1'b1;
                if (last_stage) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            sh    <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            sh    <= sh_nxt;
            k     <= k_nxt;
        end
    end

endmodule

// File: tb/tb_sll_seq.sv
`timescale 1ns/1ps
// tb_sll_seq: self-checking bench for sll_seq with N = 32.
// Expected results are queued when an operand is driven and popped when the
// DUT presents a result. Expected latency follows SLL_EARLY_EXIT_EN.
module tb_sll_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] in_d = '0;
    logic [4:0]  shamt_d = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    logic [31:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sll_seq #(.N(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .in      (in_d),
        .shamt   (shamt_d),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .out     (out),
        .busy    (busy)
    );

    function automatic int exp_s(input logic [4:0] s);
        int r;
`ifdef SLL_EARLY_EXIT_EN
        r = 1;
        for (int b = 0; b < 5; b++) if (s[b]) r = b + 1;
`else
        r = 5;
`endif
        return r;
    endfunction

    // Drive one operand, measure latency, compare result. With hold set the
    // result is left pending in DONE (o_ready low) for the caller.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic hold);
        int lat;
        logic [31:0] exp;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b want 1", i_ready);
        end
        in_d = a;
        shamt_d = s;
        i_valid = 1'b1;
        sb.push_back(a << s);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_s(s)) begin
            errors++;
            $display("FAIL latency in=%h shamt=%0d got %0d want %0d", a, s, lat, exp_s(s));
        end
        exp = sb.pop_front();
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL result in=%h shamt=%0d got %h want %h", a, s, out, exp);
        end
        if (!hold) begin
            o_ready = 1'b1;
            @(posedge clk); #1;
            o_ready = 1'b0;
            checks++;
            if (i_ready !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL return_idle got i_ready=%b o_valid=%b busy=%b want 1 0 0",
                         i_ready, o_valid, busy);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (i_ready !== 1'b0 || o_valid !== 1'b0 || busy !== 1'b0 || out !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got i_ready=%b o_valid=%b busy=%b out=%h want 0 0 0 0",
                     i_ready, o_valid, busy, out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", i_ready);
        end
    endtask

    task automatic test_basic;
        run_op(32'h00000001, 5'd31, 1'b0);
        run_op(32'hDEADBEEF, 5'd4, 1'b0);
        run_op(32'h12345678, 5'd0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_op(32'h7FFFFFFF, 5'd1, 1'b1);
        in_d = 32'h00000055;
        shamt_d = 5'd3;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || out !== 32'hFFFFFFFE || i_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got o_valid=%b out=%h i_ready=%b want 1 fffffffe 0",
                         c, o_valid, out, i_ready);
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got i_ready=%b o_valid=%b busy=%b want 1 0 0",
                     i_ready, o_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_operand got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        in_d = 32'hA5A5A5A5;
        shamt_d = 5'd7;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || out === 32'h0) begin
            errors++;
            $display("FAIL mid_shift got busy=%b out=%h want busy 1 out nonzero", busy, out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || out !== 32'h0 || busy !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got o_valid=%b out=%h busy=%b i_ready=%b want 0 0 0 0",
                     o_valid, out, busy, i_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got o_valid=%b busy=%b i_ready=%b want 0 0 0",
                     o_valid, busy, i_ready);
        end
        rst = 1'b0;
        #1;
        run_op(32'h00000003, 5'd30, 1'b0);
    endtask

    task automatic test_back_to_back;
        int n;
        int hs_cnt;
        int acc_cnt;
        int acc_e[2];
        int hs_e[2];
        logic [31:0] exp;
        acc_e = '{0, 0};
        hs_e = '{0, 0};
        in_d = 32'h1;
        shamt_d = 5'd1;
        sb.push_back(32'h2);
        i_valid = 1'b1;
        o_ready = 1'b1;
        n = 0;
        hs_cnt = 0;
        acc_cnt = 0;
        while (hs_cnt < 2 && n < 40) begin
            if (o_valid === 1'b1 && o_ready) begin
                if (sb.size() == 0) begin
                    exp = 32'hx;
                end else begin
                    exp = sb.pop_front();
                end
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL b2b_result idx=%0d got %h want %h", hs_cnt, out, exp);
                end
                hs_e[hs_cnt] = n;
                hs_cnt++;
            end
            if (i_valid && i_ready === 1'b1 && acc_cnt < 2) begin
                acc_e[acc_cnt] = n;
                acc_cnt++;
            end
            @(posedge clk); #1;
            n++;
            if (acc_cnt == 1 && shamt_d == 5'd1) begin
                shamt_d = 5'd2;
                sb.push_back(32'h4);
            end
            if (acc_cnt == 2) i_valid = 1'b0;
        end
        i_valid = 1'b0;
        o_ready = 1'b0;
        checks++;
        if (hs_cnt != 2 || acc_cnt != 2) begin
            errors++;
            $display("FAIL b2b_timeout got results=%0d accepts=%0d want 2 2", hs_cnt, acc_cnt);
        end
        checks++;
        if (acc_e[1] != hs_e[0] + 1) begin
            errors++;
            $display("FAIL b2b_reaccept got edge %0d want %0d", acc_e[1], hs_e[0] + 1);
        end
        checks++;
        if (hs_e[0] - acc_e[0] != exp_s(5'd1) + 1) begin
            errors++;
            $display("FAIL b2b_period got %0d want %0d", hs_e[0] - acc_e[0], exp_s(5'd1) + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
